alu_op_sequencer: RTL and testbench

- Multi-cycle controller that sequences one ALU operation at a time for the relay-computer datapath.
- Accepts an operation request from the instruction sequencer through a valid/ready handshake.
- Drives exactly one of the seven ALU function enables (add, inc, and, or, xor, not, shl) while the relay-modelled datapath settles, then loads the result into register A or D and captures the condition flags.
- Sits between the instruction sequencer and the ALU/result bus.

---
 rtl/alu_op_sequencer_if.sv | 21 ++
 rtl/alu_op_sequencer.sv | 154 +++++++++++++++
 tb/tb_alu_op_sequencer.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_op_sequencer_if.sv
// Request handshake between the instruction sequencer and the ALU op sequencer.
interface alu_op_sequencer_if;
    logic       op_valid;
    logic       op_ready;
    logic [2:0] op_func;
    logic       op_dest;

    modport master (
        output op_valid,
        output op_func,
        output op_dest,
        input  op_ready
    );

    modport slave (
        input  op_valid,
        input  op_func,
        input  op_dest,
        output op_ready
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Sequences one relay-ALU operation: hold the function enable while the datapath settles, then load A/D and flags.
// Optional build macro ALU_SEQ_CARRY_KEEP_EN: logical ops leave flag_c unchanged instead of clearing it.
module alu_op_sequencer #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 3
) (
    input  logic              clk,
    input  logic              reset,
    alu_op_sequencer_if.slave op,
    input  logic              alu_carry,
    input  logic              alu_zero,
    input  logic              alu_sign,
    output logic              en_add,
    output logic              en_inc,
    output logic              en_and,
    output logic              en_or,
    output logic              en_xor,
    output logic              en_not,
    output logic              en_shl,
    output logic              load_a,
    output logic              load_d,
    output logic              flag_c,
    output logic              flag_z,
    output logic              flag_s,
    output logic              busy,
    output logic              done
);
    localparam int unsigned FUNC_W     = 3;
    localparam int unsigned NUM_EN     = 7;
    localparam int unsigned SETTLE_EFF = (SETTLE_CYCLES == 0) ? 1 : SETTLE_CYCLES;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SETTLE_EFF - 1);

    localparam logic [FUNC_W-1:0] F_ADD = FUNC_W'(0);
    localparam logic [FUNC_W-1:0] F_INC = FUNC_W'(1);
    localparam logic [FUNC_W-1:0] F_SHL = FUNC_W'(6);
    localparam logic [FUNC_W-1:0] F_CLR = FUNC_W'(7);

    // The settle counter reaches SETTLE_EFF on the last SETTLE edge and must not wrap.
    if ((64'd1 << CNT_W) <= 64'(SETTLE_EFF)) begin : g_cnt_check
        $error("alu_op_sequencer: CNT_W too small for SETTLE_CYCLES");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        LATCH  = 2'd2
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    count;
    logic [FUNC_W-1:0]   func_q;
    logic                dest_q;
    logic [NUM_EN-1:0]   en_q;
    logic                op_ready_q;

    // clr maps to no enable so the result bus floats to zero.
    function automatic logic [NUM_EN-1:0] func_onehot(input logic [FUNC_W-1:0] f);
        logic [NUM_EN-1:0] oh;
        oh = '0;
        case (f)
            3'd0:    oh = 7'b000_0001;
            3'd1:    oh = 7'b000_0010;
            3'd2:    oh = 7'b000_0100;
            3'd3:    oh = 7'b000_1000;
            3'd4:    oh = 7'b001_0000;
            3'd5:    oh = 7'b010_0000;
            3'd6:    oh = 7'b100_0000;
            default: oh = '0;
        endcase
        return oh;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            count      <= '0;
            func_q     <= '0;
            dest_q     <= 1'b0;
            en_q       <= '0;
            op_ready_q <= 1'b0;
            load_a     <= 1'b0;
            load_d     <= 1'b0;
            done       <= 1'b0;
            busy       <= 1'b0;
            flag_c     <= 1'b0;
            flag_z     <= 1'b0;
            flag_s     <= 1'b0;
        end else begin
            load_a <= 1'b0;
            load_d <= 1'b0;
            done   <= 1'b0;
            case (state)
                IDLE: begin
                    op_ready_q <= 1'b1;
                    if (op.op_valid && op_ready_q) begin
                        func_q     <= op.op_func;
                        dest_q     <= op.op_dest;
                        count      <= '0;
                        en_q       <= func_onehot(op.op_func);
                        busy       <= 1'b1;
                        op_ready_q <= 1'b0;
                        state      <= SETTLE;
                    end
                end
                SETTLE: begin
                    count <= count + 1'b1;
                    if (count == LAST_CNT) begin
                        load_a <= ~dest_q;
                        load_d <= dest_q;
                        done   <= 1'b1;
                        state  <= LATCH;
                    end
                end
                LATCH: begin
                    en_q       <= '0;
                    busy       <= 1'b0;
                    op_ready_q <= 1'b1;
                    state      <= IDLE;
                    flag_z     <= alu_zero;
                    flag_s     <= alu_sign;
                    // Carry is meaningful only for the arithmetic and shift paths.
                    if (func_q == F_ADD || func_q == F_INC || func_q == F_SHL) begin
                        flag_c <= alu_carry;
                    end else if (func_q == F_CLR) begin
                        flag_c <= 1'b0;
                        flag_z <= 1'b1;
                        flag_s <= 1'b0;
                    end else begin
`ifdef ALU_SEQ_CARRY_KEEP_EN
                        flag_c <= flag_c;
`else
                        flag_c <= 1'b0;
`endif
                    end
                end
                default: begin
                    en_q       <= '0;
                    busy       <= 1'b0;
                    op_ready_q <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

    assign op.op_ready = op_ready_q;
    assign en_add      = en_q[0];
    assign en_inc      = en_q[1];
    assign en_and      = en_q[2];
    assign en_or       = en_q[3];
    assign en_xor      = en_q[4];
    assign en_not      = en_q[5];
    assign en_shl      = en_q[6];
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Self-checking bench for alu_op_sequencer: cycle monitor plus a request/result scoreboard.
module tb_alu_op_sequencer;
    localparam int SETTLE = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic alu_carry = 1'b0;
    logic alu_zero = 1'b0;
    logic alu_sign = 1'b0;
    logic en_add, en_inc, en_and, en_or, en_xor, en_not, en_shl;
    logic load_a, load_d, flag_c, flag_z, flag_s, busy, done;
    logic [6:0] en;

    always #5 clk = ~clk;

    alu_op_sequencer_if bus ();

    alu_op_sequencer #(.SETTLE_CYCLES(SETTLE), .CNT_W(3)) dut (
        .clk(clk), .reset(reset), .op(bus),
        .alu_carry(alu_carry), .alu_zero(alu_zero), .alu_sign(alu_sign),
        .en_add(en_add), .en_inc(en_inc), .en_and(en_and), .en_or(en_or),
        .en_xor(en_xor), .en_not(en_not), .en_shl(en_shl),
        .load_a(load_a), .load_d(load_d),
        .flag_c(flag_c), .flag_z(flag_z), .flag_s(flag_s),
        .busy(busy), .done(done)
    );

    assign en = {en_shl, en_not, en_xor, en_or, en_and, en_inc, en_add};

    typedef struct {
        logic [2:0] func;
        logic       dest;
    } req_t;

    req_t q[$];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int n_acc = 0;
    int n_done = 0;
    int last_done = 0;
    int prev_done = 0;
    logic inflight = 1'b0;
    logic ready_ok = 1'b0;
    logic pend = 1'b0;
    logic [2:0] cur_func = 3'd0;
    logic [2:0] pflags = 3'd0;
    logic mc = 1'b0, mz = 1'b0, ms = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [6:0] dec(input logic [2:0] f);
        case (f)
            3'd0:    return 7'b000_0001;
            3'd1:    return 7'b000_0010;
            3'd2:    return 7'b000_0100;
            3'd3:    return 7'b000_1000;
            3'd4:    return 7'b001_0000;
            3'd5:    return 7'b010_0000;
            3'd6:    return 7'b100_0000;
            default: return 7'b000_0000;
        endcase
    endfunction

    function automatic logic [2:0] exp_flags(input logic [2:0] f, input logic c_prev,
                                             input logic c, input logic z, input logic s);
        case (f)
            3'd0, 3'd1, 3'd6: return {c, z, s};
            3'd7:             return 3'b010;
`ifdef ALU_SEQ_CARRY_KEEP_EN
            default:          return {c_prev, z, s};
`else
            default:          return {1'b0, z, s};
`endif
        endcase
    endfunction

    // One clock: update the model from what the edge saw, then check every output.
    task automatic step();
        logic       rst_edge, acc_edge, a_dest;
        logic [2:0] a_func;
        logic       exp_busy, exp_done;
        req_t       e;
        rst_edge = reset;
        acc_edge = !reset && bus.op_valid && bus.op_ready;
        a_func   = bus.op_func;
        a_dest   = bus.op_dest;
        @(posedge clk);
        #1;
        cyc++;
        if (rst_edge) begin
            q.delete();
            inflight = 1'b0;
            pend     = 1'b0;
            ready_ok = 1'b0;
            {mc, mz, ms} = 3'b000;
        end else begin
            ready_ok = 1'b1;
            if (pend) begin
                {mc, mz, ms} = pflags;
                pend = 1'b0;
            end
            if (inflight && (cyc - acc_cyc) == SETTLE + 1) inflight = 1'b0;
            if (acc_edge) begin
                inflight = 1'b1;
                acc_cyc  = cyc;
                cur_func = a_func;
                q.push_back('{func: a_func, dest: a_dest});
                n_acc++;
            end
        end
        exp_busy = inflight && ((cyc - acc_cyc) <= SETTLE);
        exp_done = inflight && ((cyc - acc_cyc) == SETTLE);
        chk("busy", 32'(busy), 32'(exp_busy));
        chk("done", 32'(done), 32'(exp_done));
        chk("enables", 32'(en), exp_busy ? 32'(dec(cur_func)) : 32'd0);
        chk("op_ready", 32'(bus.op_ready), 32'(ready_ok && !inflight));
        chk("flags", 32'({flag_c, flag_z, flag_s}), 32'({mc, mz, ms}));
        if (exp_done) begin
            if (q.size() == 0) begin
                chk("scoreboard_empty", 32'd0, 32'd1);
            end else begin
                e = q.pop_front();
                chk("load_a", 32'(load_a), 32'(!e.dest));
                chk("load_d", 32'(load_d), 32'(e.dest));
                pflags = exp_flags(e.func, mc, alu_carry, alu_zero, alu_sign);
                pend   = 1'b1;
            end
            prev_done = last_done;
            last_done = cyc;
            n_done++;
        end else begin
            chk("load_a_quiet", 32'(load_a), 32'd0);
            chk("load_d_quiet", 32'(load_d), 32'd0);
        end
    endtask

    task automatic run_op(input logic [2:0] f, input logic d,
                          input logic c, input logic z, input logic s);
        int n;
        int k;
        bus.op_func  = f;
        bus.op_dest  = d;
        alu_carry    = c;
        alu_zero     = z;
        alu_sign     = s;
        bus.op_valid = 1'b1;
        n = n_acc;
        k = 0;
        while (n_acc == n && k < 20) begin
            step();
            k++;
        end
        if (n_acc == n) chk("accept_timeout", 32'd0, 32'd1);
        bus.op_valid = 1'b0;
        n = n_done;
        k = 0;
        while (n_done == n && k < 20) begin
            step();
            k++;
        end
        if (n_done == n) chk("done_timeout", 32'd0, 32'd1);
        step();
    endtask

    initial begin
        int a1;
        int a2;
        int k;
        bus.op_valid = 1'b0;
        bus.op_func  = 3'd0;
        bus.op_dest  = 1'b0;

        // Reset then idle.
        step();
        step();
        reset = 1'b0;
        repeat (3) step();
        chk("rst_ready", 32'(bus.op_ready), 32'd1);
        chk("rst_flags", 32'({flag_c, flag_z, flag_s}), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_en", 32'(en), 32'd0);

        // add to A: carry=1 zero=0 sign=1.
        run_op(3'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("add_latency", 32'(last_done - acc_cyc), 32'(SETTLE));
        chk("add_flags", 32'({flag_c, flag_z, flag_s}), 32'b101);
        chk("add_ready", 32'(bus.op_ready), 32'd1);

        // clr to D with misleading ALU inputs.
        run_op(3'd7, 1'b1, 1'b1, 1'b0, 1'b1);
        chk("clr_flags", 32'({flag_c, flag_z, flag_s}), 32'b010);

        // Carry set by add, then xor to A.
        run_op(3'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("pre_xor_c", 32'(flag_c), 32'd1);
        run_op(3'd4, 1'b0, 1'b1, 1'b1, 1'b0);
`ifdef ALU_SEQ_CARRY_KEEP_EN
        chk("xor_c", 32'(flag_c), 32'd1);
`else
        chk("xor_c", 32'(flag_c), 32'd0);
`endif
        chk("xor_z", 32'(flag_z), 32'd1);

        // Back-to-back: shl then inc with op_valid held high.
        bus.op_func  = 3'd6;
        bus.op_dest  = 1'b1;
        alu_carry    = 1'b1;
        alu_zero     = 1'b0;
        alu_sign     = 1'b0;
        bus.op_valid = 1'b1;
        k = n_acc;
        a1 = 0;
        for (int i = 0; i < 20 && n_acc == k; i++) step();
        a1 = acc_cyc;
        bus.op_func = 3'd1;
        bus.op_dest = 1'b0;
        k = n_acc;
        for (int i = 0; i < 20 && n_acc == k; i++) step();
        a2 = acc_cyc;
        bus.op_valid = 1'b0;
        chk("b2b_accept_gap", 32'(a2 - a1), 32'(SETTLE + 2));
        k = n_done;
        for (int i = 0; i < 20 && n_done == k; i++) step();
        chk("b2b_done_gap", 32'(last_done - prev_done), 32'(SETTLE + 2));
        step();
        chk("inc_flags", 32'({flag_c, flag_z, flag_s}), 32'b100);

        // Reset in the middle of an add to A.
        bus.op_func  = 3'd0;
        bus.op_dest  = 1'b0;
        alu_carry    = 1'b1;
        alu_zero     = 1'b1;
        alu_sign     = 1'b1;
        bus.op_valid = 1'b1;
        k = n_acc;
        for (int i = 0; i < 20 && n_acc == k; i++) step();
        bus.op_valid = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_en", 32'(en), 32'd0);
        chk("rst_mid_load", 32'({load_a, load_d, done}), 32'd0);
        chk("rst_mid_flags", 32'({flag_c, flag_z, flag_s}), 32'd0);
        reset = 1'b0;
        k = n_done;
        repeat (8) step();
        chk("rst_mid_no_done", 32'(n_done - k), 32'd0);
        run_op(3'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("post_rst_flags", 32'({flag_c, flag_z, flag_s}), 32'b001);

        // Random mix of functions, destinations and ALU inputs.
        for (int i = 0; i < 20; i++) begin
            run_op(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
